dram_write_buffer: RTL and testbench

- Write-back buffer between the cache controller (upstream) and dataram (downstream), in the clk domain.
- Accepts 128-bit block writes from the cache and completes them in 1 cycle, then drains them to DRAM in the background.
- Serves block reads by forwarding from buffered entries, or by a direct DRAM read, so cache refills never see stale data.

---
 rtl/dram_write_buffer_pkg.sv | 19 +
 rtl/dram_write_buffer_match.sv | 42 ++++
 rtl/dram_write_buffer.sv | 166 ++++++++++++++++
 tb/tb_dram_write_buffer.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_write_buffer_pkg.sv
// Shared types and constants for the DRAM write-back buffer.
// The optional in-place write coalescing feature is enabled by defining WB_COALESCE_EN.
package dram_write_buffer_pkg;

   localparam int WB_DEPTH  = 4;
   localparam int BLOCK_W   = 128;

   // Block address width shared with the dataram address port
   localparam int WB_ADDR_W = 10;

   // Background DRAM port sequencer; forwarding and write accepts never go through it
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_READ  = 2'd2,
      ST_RESP  = 2'd3
   } wb_state_t;

endpackage

// File: rtl/dram_write_buffer_match.sv
// Address comparator over the occupied FIFO slots: reports the youngest match overall
// and the youngest match that may be overwritten in place (never the head while it drains).
module wb_match #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  parameter int PTR_W  = 2,
  parameter int CNT_W  = 3
) (
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  entry_addr,
  input  logic [PTR_W-1:0]              head,
  input  logic [CNT_W-1:0]              count,
  input  logic                          head_busy,
  output logic                          hit,
  output logic [PTR_W-1:0]              hit_idx,
  output logic                          co_hit,
  output logic [PTR_W-1:0]              co_idx
);

  logic [PTR_W-1:0] idx;

  // Scan oldest to youngest so later matches override earlier ones
  always_comb begin
    hit     = 1'b0;
    hit_idx = head;
    co_hit  = 1'b0;
    co_idx  = head;
    idx     = head;
    for (int age = 0; age < DEPTH; age++) begin
      idx = head + PTR_W'(age);
      if ((CNT_W'(age) < count) && (entry_addr[idx] == req_addr)) begin
        hit     = 1'b1;
        hit_idx = idx;
        if (!(head_busy && (age == 0))) begin
          co_hit = 1'b1;
          co_idx = idx;
        end
      end
    end
  end

endmodule

// File: rtl/dram_write_buffer.sv
// Write-back buffer between the cache and dataram: single-cycle block writes, background drain,
// read forwarding from buffered entries. Define WB_COALESCE_EN to overwrite matching entries in place.
module dram_write_buffer
  import dram_write_buffer_pkg::*;
#(
  parameter int DEPTH  = WB_DEPTH,
  parameter int ADDR_W = WB_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_we,
  input  logic                         req_re,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [BLOCK_W-1:0]           req_din,
  output logic [BLOCK_W-1:0]           req_dout,
  output logic                         req_complete,
  output logic                         dram_we,
  output logic                         dram_re,
  output logic [ADDR_W-1:0]            dram_addr,
  output logic [BLOCK_W-1:0]           dram_din,
  input  logic [BLOCK_W-1:0]           dram_dout,
  input  logic                         dram_complete,
  output logic [$clog2(DEPTH+1)-1:0]   buf_count,
  output logic                         buf_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

`ifdef WB_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif

  wb_state_t state, state_nxt;

  logic [DEPTH-1:0][ADDR_W-1:0]  fifo_addr;
  logic [DEPTH-1:0][BLOCK_W-1:0] fifo_data;
  logic [PTR_W-1:0]              head, tail;
  logic [CNT_W-1:0]              count;

  logic               resp_valid;
  logic [BLOCK_W-1:0] resp_data;
  logic [BLOCK_W-1:0] rd_data;

  logic               hit, co_hit;
  logic [PTR_W-1:0]   hit_idx, co_idx;

  logic sample, wr_req, rd_req, wr_coal, wr_push, wr_accept, rd_hit, rd_miss, pop;

  wb_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PTR_W  (PTR_W),
    .CNT_W  (CNT_W)
  ) u_match (
    .req_addr   (req_addr),
    .entry_addr (fifo_addr),
    .head       (head),
    .count      (count),
    .head_busy  (state == ST_DRAIN),
    .hit        (hit),
    .hit_idx    (hit_idx),
    .co_hit     (co_hit),
    .co_idx     (co_idx)
  );

  // A held request is ignored while its completion is showing or while a miss owns the DRAM port
  always_comb begin
    sample    = !req_complete && (state != ST_READ) && (state != ST_RESP);
    wr_req    = sample && req_we;
    rd_req    = sample && !req_we && req_re;
    wr_coal   = COALESCE && wr_req && co_hit;
    wr_push   = wr_req && !wr_coal && (count < CNT_W'(DEPTH));
    wr_accept = wr_push || wr_coal;
    rd_hit    = rd_req && hit;
    rd_miss   = rd_req && !hit;
    pop       = (state == ST_DRAIN) && dram_complete;
  end

  always_ff @(posedge clk) begin
    if (wr_push) begin
      fifo_addr[tail] <= req_addr;
      fifo_data[tail] <= req_din;
    end else if (wr_coal) begin
      fifo_data[co_idx] <= req_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_push) tail <= tail + PTR_W'(1);
      if (pop)     head <= head + PTR_W'(1);
      case ({wr_push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      rd_data    <= '0;
    end else begin
      resp_valid <= wr_accept || rd_hit;
      if (rd_hit) resp_data <= fifo_data[hit_idx];
      if ((state == ST_READ) && dram_complete) rd_data <= dram_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // A waiting read miss wins over starting the next drain
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (rd_miss)            state_nxt = ST_READ;
        else if (count != '0)   state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (dram_complete) state_nxt = ST_IDLE;
      ST_READ:  if (dram_complete) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    dram_we      = 1'b0;
    dram_re      = 1'b0;
    dram_addr    = '0;
    dram_din     = '0;
    req_complete = resp_valid;
    req_dout     = resp_data;
    case (state)
      ST_DRAIN: begin
        dram_we   = 1'b1;
        dram_addr = fifo_addr[head];
        dram_din  = fifo_data[head];
      end
      ST_READ: begin
        dram_re   = 1'b1;
        dram_addr = req_addr;
      end
      ST_RESP: begin
        req_complete = 1'b1;
        req_dout     = rd_data;
      end
      default: ;
    endcase
    buf_count = count;
    buf_empty = (count == '0);
  end

endmodule

// File: tb/tb_dram_write_buffer.sv
// Self-checking bench for dram_write_buffer: a DRAM responder plus a queue/memory reference model.
// Expectations follow WB_COALESCE_EN when it is defined for the build.
module tb_dram_write_buffer;
  import dram_write_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = WB_ADDR_W;

  typedef struct {
    logic [AW-1:0] addr;
    logic [127:0]  data;
  } ent_t;

  logic           clk, rst;
  logic           req_we, req_re;
  logic [AW-1:0]  req_addr;
  logic [127:0]   req_din, req_dout;
  logic           req_complete;
  logic           dram_we, dram_re;
  logic [AW-1:0]  dram_addr;
  logic [127:0]   dram_din, dram_dout;
  logic           dram_complete;
  logic [$clog2(DEPTH+1)-1:0] buf_count;
  logic           buf_empty;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [127:0] mem [1<<AW];
  ent_t q[$];
  int   kind_log[$];
  int   addr_log[$];
  int   cyc_log[$];

  bit stall = 0;
  bit fixed_lat = 0;
  bit started = 0;
  int lat = 0;
  int waited = 0;

  dram_write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_we(req_we), .req_re(req_re), .req_addr(req_addr), .req_din(req_din),
    .req_dout(req_dout), .req_complete(req_complete),
    .dram_we(dram_we), .dram_re(dram_re), .dram_addr(dram_addr), .dram_din(dram_din),
    .dram_dout(dram_dout), .dram_complete(dram_complete),
    .buf_count(buf_count), .buf_empty(buf_empty)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // DRAM responder: drains must leave the buffer oldest-first with the data the model holds
  always @(negedge clk) begin
    if (!rst && dram_we && dram_re) begin
      checks++; failures++;
      $display("[TB] FAIL dram_mutex: dram_we=1 dram_re=1 required not both");
    end
    if (rst) begin
      dram_complete = 0; started = 0;
    end else if (dram_complete) begin
      dram_complete = 0; started = 0;
    end else if ((dram_we || dram_re) && !stall) begin
      if (!started) begin
        started = 1; waited = 0;
        lat = fixed_lat ? 0 : int'($urandom_range(0, 3));
      end
      if (waited >= lat) begin
        dram_complete = 1;
        cyc_log.push_back(cyc);
        addr_log.push_back(int'(dram_addr));
        if (dram_we) begin
          kind_log.push_back(1);
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("[TB] FAIL drain_order: drained addr=%h while model buffer empty", dram_addr);
          end else begin
            if (q[0].addr !== dram_addr || q[0].data !== dram_din) begin
              failures++;
              $display("[TB] FAIL drain_order: got addr=%h data=%h required addr=%h data=%h",
                       dram_addr, dram_din, q[0].addr, q[0].data);
            end
            void'(q.pop_front());
          end
          mem[dram_addr] = dram_din;
        end else begin
          kind_log.push_back(2);
          dram_dout = mem[dram_addr];
        end
      end else begin
        waited++;
      end
    end
  end

  function automatic logic [127:0] logical(input logic [AW-1:0] a);
    logic [127:0] v;
    v = mem[a];
    foreach (q[i]) if (q[i].addr == a) v = q[i].data;
    return v;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [127:0] d, input bit inflight);
`ifdef WB_COALESCE_EN
    int idx;
    idx = -1;
    for (int i = (inflight ? 1 : 0); i < q.size(); i++) if (q[i].addr == a) idx = i;
    if (idx >= 0) begin
      q[idx].data = d;
      return;
    end
`else
    if (inflight) begin end
`endif
    q.push_back('{addr: a, data: d});
  endfunction

  task automatic do_write(input logic [AW-1:0] a, input logic [127:0] d, input int max_cyc,
                          output int lat_out, output int done_cyc, output int dut_cnt, output int model_cnt);
    bit inflight, done;
    int n;
    @(negedge clk); #2;
    inflight = dram_we && !dram_complete;
    req_we = 1; req_re = 0; req_addr = a; req_din = d;
    n = 0; done = 0; done_cyc = -1; dut_cnt = -1; model_cnt = -1;
    while (!done && n < max_cyc) begin
      @(posedge clk); #1; n++;
      if (req_complete) done = 1;
      else begin
        @(negedge clk); #2;
        inflight = dram_we && !dram_complete;
      end
    end
    if (done) begin
      model_write(a, d, inflight);
      done_cyc = cyc; dut_cnt = int'(buf_count); model_cnt = q.size();
      lat_out = n;
    end else begin
      checks++; failures++;
      $display("[TB] FAIL write_timeout: addr=%h no req_complete within %0d cycles", a, max_cyc);
      lat_out = -1;
    end
    @(negedge clk); #2;
    req_we = 0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int max_cyc,
                         output logic [127:0] dout, output int lat_out, output int done_cyc);
    bit done;
    int n;
    @(negedge clk); #2;
    req_we = 0; req_re = 1; req_addr = a;
    n = 0; done = 0; done_cyc = -1; dout = '0;
    while (!done && n < max_cyc) begin
      @(posedge clk); #1; n++;
      if (req_complete) done = 1;
      else @(negedge clk);
    end
    if (done) begin
      dout = req_dout; done_cyc = cyc; lat_out = n;
    end else begin
      checks++; failures++;
      $display("[TB] FAIL read_timeout: addr=%h no req_complete within %0d cycles", a, max_cyc);
      lat_out = -1;
    end
    @(negedge clk); #2;
    req_re = 0;
  endtask

  task automatic wait_empty(input string tag);
    int n;
    n = 0;
    while (!buf_empty && n < 300) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (!buf_empty || q.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_drain_all: buf_count=%0d model=%0d required 0", tag, buf_count, q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1; req_we = 0; req_re = 0; req_addr = '0; req_din = '0;
    dram_complete = 0; dram_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (req_complete !== 1'b0 || req_dout !== '0) begin
      failures++; $display("[TB] FAIL reset_req: complete=%b dout=%h required 0/0", req_complete, req_dout);
    end
    if (dram_we !== 1'b0 || dram_re !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_dram_ctl: we=%b re=%b required 0/0", dram_we, dram_re);
    end
    if (dram_addr !== '0 || dram_din !== '0) begin
      failures++; $display("[TB] FAIL reset_dram_bus: addr=%h din=%h required 0", dram_addr, dram_din);
    end
    if (buf_count !== '0) begin
      failures++; $display("[TB] FAIL reset_count: got %0d required 0", buf_count);
    end
    if (buf_empty !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_empty: got %b required 1", buf_empty);
    end
    @(negedge clk); #2;
    rst = 0;
  endtask

  task automatic test_single_write();
    logic [127:0] a_data;
    int l, dc, dn, mn, n;
    a_data = 128'hA5A5_0001_1111_2222_3333_4444_5555_6666;
    stall = 1;
    do_write(AW'('h010), a_data, 20, l, dc, dn, mn);
    checks += 2;
    if (l != 1) begin
      failures++; $display("[TB] FAIL single_latency: got %0d cycles required 1", l);
    end
    if (dn != 1) begin
      failures++; $display("[TB] FAIL single_count: got %0d required 1", dn);
    end
    n = 0;
    while (!dram_we && n < 10) begin @(posedge clk); #1; n++; end
    checks += 2;
    if (dram_we !== 1'b1) begin
      failures++; $display("[TB] FAIL single_drain_start: dram_we=%b required 1", dram_we);
    end
    if (dram_addr !== AW'('h010) || dram_din !== a_data) begin
      failures++; $display("[TB] FAIL single_drain_bus: addr=%h din=%h required 010/%h", dram_addr, dram_din, a_data);
    end
    stall = 0;
    n = 0;
    while (buf_count != 0 && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (buf_count !== '0 || buf_empty !== 1'b1 || mem[AW'('h010)] !== a_data) begin
      failures++; $display("[TB] FAIL single_drained: count=%0d empty=%b mem=%h required 0/1/%h",
                           buf_count, buf_empty, mem[AW'('h010)], a_data);
    end
  endtask

  task automatic test_full();
    int l, dc, dn, mn, l5, dc5, dn5, mn5;
    stall = 1; fixed_lat = 1;
    for (int i = 1; i <= 4; i++) begin
      do_write(AW'(i), {4{$urandom}}, 20, l, dc, dn, mn);
      checks += 2;
      if (l != 1) begin
        failures++; $display("[TB] FAIL full_accept_lat%0d: got %0d cycles required 1", i, l);
      end
      if (dn != i) begin
        failures++; $display("[TB] FAIL full_count%0d: got %0d required %0d", i, dn, i);
      end
    end
    cyc_log.delete();
    fork
      do_write(AW'(5), {4{$urandom}}, 80, l5, dc5, dn5, mn5);
      begin
        repeat (8) @(posedge clk);
        #2 stall = 0;
      end
    join
    checks += 2;
    if (cyc_log.size() == 0 || dc5 != cyc_log[0] + 2) begin
      failures++; $display("[TB] FAIL full_fifth_timing: completed cycle %0d required %0d",
                           dc5, (cyc_log.size() == 0) ? -1 : cyc_log[0] + 2);
    end
    if (dn5 != mn5 || dn5 != DEPTH) begin
      failures++; $display("[TB] FAIL full_fifth_count: got %0d required %0d", dn5, DEPTH);
    end
    fixed_lat = 0;
    wait_empty("full");
  endtask

  task automatic test_forward();
    logic [127:0] a_data, b_data, dout;
    int l, dc, dn, mn, rd_before, exp_cnt;
    a_data = {4{32'hAAAA_0020}};
    b_data = {4{32'hBBBB_0020}};
    stall = 1;
    do_write(AW'('h070), {4{$urandom}}, 20, l, dc, dn, mn);
    do_write(AW'('h020), a_data, 20, l, dc, dn, mn);
    do_write(AW'('h020), b_data, 20, l, dc, dn, mn);
    rd_before = 0;
    foreach (kind_log[i]) if (kind_log[i] == 2) rd_before++;
    do_read(AW'('h020), 20, dout, l, dc);
`ifdef WB_COALESCE_EN
    exp_cnt = 2;
`else
    exp_cnt = 3;
`endif
    checks += 4;
    if (dout !== b_data) begin
      failures++; $display("[TB] FAIL fwd_data: got %h required %h", dout, b_data);
    end
    if (l != 1) begin
      failures++; $display("[TB] FAIL fwd_latency: got %0d required 1", l);
    end
    if (dram_re !== 1'b0) begin
      failures++; $display("[TB] FAIL fwd_no_dram_re: dram_re=%b required 0", dram_re);
    end
    if (buf_count !== exp_cnt[$clog2(DEPTH+1)-1:0]) begin
      failures++; $display("[TB] FAIL fwd_count: got %0d required %0d", buf_count, exp_cnt);
    end
    stall = 0;
    wait_empty("fwd");
    begin
      int rd_after;
      rd_after = 0;
      foreach (kind_log[i]) if (kind_log[i] == 2) rd_after++;
      checks++;
      if (rd_after != rd_before) begin
        failures++; $display("[TB] FAIL fwd_dram_reads: got %0d reads required %0d", rd_after, rd_before);
      end
    end
  endtask

  task automatic test_read_miss();
    logic [127:0] exp, dout;
    int l, dc, dn, mn;
    stall = 1;
    do_write(AW'('h040), {4{$urandom}}, 20, l, dc, dn, mn);
    do_write(AW'('h050), {4{$urandom}}, 20, l, dc, dn, mn);
    kind_log.delete(); addr_log.delete(); cyc_log.delete();
    exp = logical(AW'('h030));
    fork
      do_read(AW'('h030), 80, dout, l, dc);
      begin
        repeat (6) @(posedge clk);
        #2;
        checks++;
        if (dram_re !== 1'b0 || dram_we !== 1'b1) begin
          failures++; $display("[TB] FAIL miss_wait: dram_re=%b dram_we=%b required 0/1", dram_re, dram_we);
        end
        stall = 0;
      end
    join
    checks += 3;
    if (kind_log.size() < 2 || kind_log[0] != 1 || addr_log[0] != 'h040 || kind_log[1] != 2 || addr_log[1] != 'h030) begin
      failures++; $display("[TB] FAIL miss_order: first two DRAM ops kind/addr %0d/%h %0d/%h required 1/040 2/030",
                           (kind_log.size() > 0) ? kind_log[0] : 0, (addr_log.size() > 0) ? addr_log[0] : 0,
                           (kind_log.size() > 1) ? kind_log[1] : 0, (addr_log.size() > 1) ? addr_log[1] : 0);
    end
    if (dout !== exp) begin
      failures++; $display("[TB] FAIL miss_data: got %h required %h", dout, exp);
    end
    if (cyc_log.size() < 2 || dc != cyc_log[1] + 1) begin
      failures++; $display("[TB] FAIL miss_timing: completed cycle %0d required %0d",
                           dc, (cyc_log.size() > 1) ? cyc_log[1] + 1 : -1);
    end
    wait_empty("miss");
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [127:0]  d, exp, dout;
    int l, dc, dn, mn;
    stall = 0; fixed_lat = 0;
    for (int i = 0; i < 80; i++) begin
      a = AW'('h100 + $urandom_range(0, 7));
      if ($urandom_range(0, 9) < 6) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        do_write(a, d, 100, l, dc, dn, mn);
        checks++;
        if (dn != mn) begin
          failures++; $display("[TB] FAIL rand_count%0d: got %0d required %0d", i, dn, mn);
        end
      end else begin
        exp = logical(a);
        do_read(a, 100, dout, l, dc);
        checks++;
        if (dout !== exp) begin
          failures++; $display("[TB] FAIL rand_read%0d: addr=%h got %h required %h", i, a, dout, exp);
        end
      end
    end
    wait_empty("rand");
  endtask

  task automatic test_reset_mid_drain();
    int l, dc, dn, mn, active, ops_before;
    stall = 1;
    for (int i = 0; i < 3; i++) do_write(AW'('h200 + i), {4{$urandom}}, 20, l, dc, dn, mn);
    checks++;
    if (dram_we !== 1'b1 || buf_count !== 3) begin
      failures++; $display("[TB] FAIL rst_setup: dram_we=%b count=%0d required 1/3", dram_we, buf_count);
    end
    @(negedge clk); #2;
    rst = 1;
    #1;
    checks += 2;
    if (dram_we !== 1'b0 || dram_addr !== '0) begin
      failures++; $display("[TB] FAIL rst_dram_we: dram_we=%b addr=%h required 0/0", dram_we, dram_addr);
    end
    if (buf_count !== '0 || buf_empty !== 1'b1) begin
      failures++; $display("[TB] FAIL rst_count: count=%0d empty=%b required 0/1", buf_count, buf_empty);
    end
    q.delete();
    ops_before = kind_log.size();
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rst = 0; stall = 0;
    active = 0;
    repeat (12) begin
      @(negedge clk); #2;
      if (dram_we || dram_re) active++;
    end
    checks++;
    if (active != 0 || kind_log.size() != ops_before) begin
      failures++; $display("[TB] FAIL rst_quiet: active cycles=%0d new ops=%0d required 0/0",
                           active, kind_log.size() - ops_before);
    end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    test_reset();
    test_single_write();
    test_full();
    test_forward();
    test_read_miss();
    test_random();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
